jt10_adpcm_mix: RTL and testbench
=================================

JT10_ADPCM_MIX -- requirements
Module: jt10_adpcm_mix

Interface
REQ-001 SHALL have parameter ACC_W, default 19, meaning accumulator width in bits (signed, two's complement).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port cen  input  1  clock enable (666 kHz); state changes only when high, except reset.
REQ-005 SHALL have port en_ch  input  6  one-hot channel tag for the sample on pcm_in.
REQ-006 SHALL have port match  input  1  pcm_in/lr valid for channel en_ch in this cen cycle.
REQ-007 SHALL have port lr  input  2  pan bits; bit1 = left enable, bit0 = right enable.
REQ-008 SHALL have port pcm_in  input  16  signed attenuated channel sample from the gain stage.
REQ-009 SHALL have port pcm_left  output  16  signed mixed left output, saturated.
REQ-010 SHALL have port pcm_right  output  16  signed mixed right output, saturated.
REQ-011 SHALL have port sample  output  1  one-clk pulse when pcm_left/pcm_right update.

Function
REQ-012 A valid input event SHALL be cen=1 and match=1 in the same clk cycle; no other cycle alters state.
REQ-013 On a valid event, pcm_in sign-extended to ACC_W SHALL be added to acc_l when lr[1]=1 and to acc_r when lr[0]=1; lr=00 contributes nothing.
REQ-014 A valid event with en_ch[5]=1 SHALL be the frame end: next acc value (including this sample) is saturated to 16 bits and registered into pcm_left/pcm_right, and both accumulators SHALL be cleared to 0 in the same edge.
REQ-015 Saturation SHALL clamp values > 32767 to 32767 and < -32768 to -32768; in-range values pass unchanged.
REQ-016 sample SHALL be 1 for exactly one clk cycle following each frame-end edge that updates outputs, else 0; it is not gated by cen.
REQ-017 Latency: outputs SHALL reflect the frame on the clk edge of the channel-5 valid event (one register stage).
REQ-018 A synced flag SHALL be cleared by reset and set at the first frame end; while clear, accumulators SHALL stay 0 and the frame end SHALL only set synced, not update outputs nor pulse sample (partial first frame discarded).
REQ-019 en_ch value other than bit 5 set (zero or multi-hot without bit 5) SHALL be accumulated normally; multi-hot with bit 5 set SHALL be treated as frame end.
REQ-020 ACC_W=19 SHALL hold the worst-case sum of six samples (-196608..196602) without overflow; no wrap-around SHALL occur.
REQ-021 Outputs SHALL hold their value between frame ends, including when cen stays low indefinitely.

Reset
REQ-022 While rst=1 on a clk edge: acc_l, acc_r, pcm_left, pcm_right SHALL become 0, sample 0, synced 0.
REQ-023 Reset asserted mid-frame SHALL discard partial sums; the next frame after release is treated per REQ-018.
REQ-024 rst SHALL take priority over cen and match.

Structure
REQ-025 Shared package SHALL hold ACC_W default, channel count (6), frame-end channel index (5) and the 16-bit saturation limits.
REQ-026 One sub-module, jt10_adpcm_sat (ACC_W-bit signed in, 16-bit saturated out, combinational), SHALL be instantiated twice (left, right).
REQ-027 Accumulators and output registers SHALL be the only sequential state besides synced and the sample pulse register.

Verification
REQ-028 Reset release, then frame ch0..ch5 of 100 each, lr=11 -> no sample pulse, outputs 0 (sync frame); second identical frame -> sample pulse, pcm_left=pcm_right=600.
REQ-029 Synced, six samples of 30000 lr=10 -> pcm_left=32767, pcm_right=0; six samples of -30000 lr=01 -> pcm_left=0, pcm_right=-32768.
REQ-030 Synced, ch0=1000 lr=10, ch1=-250 lr=01, ch2=500 lr=00, ch3..ch5=0 -> pcm_left=1000, pcm_right=-250; next frame of all 0 -> both 0.
REQ-031 Synced, match=1 but cen=0 for 20 cycles with pcm_in=5000 -> accumulators and outputs unchanged, no sample pulse.
REQ-032 Synced, ch0..ch2 of 7000 lr=11, assert rst one cycle, then two full frames of 10 -> outputs 0 after reset, first frame discarded, second gives 60/60.

Source files
------------

// File: rtl/jt10_adpcm_mix_pkg.sv
// Shared constants for the ADPCM channel mixer: accumulator width, channel layout
// and the 16-bit output saturation limits.
package jt10_adpcm_mix_pkg;

   localparam int ACC_W_DEF = 19;
   localparam int NUM_CH    = 6;
   localparam int FRAME_CH  = 5;

   localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN = 16'sh8000;

   // Channel 5 closes the frame; any other tag, including zero or multi-hot, just accumulates.
   function automatic logic is_frame_end(input logic [NUM_CH-1:0] en_ch);
      is_frame_end = en_ch[FRAME_CH];
   endfunction

endpackage

// File: rtl/jt10_adpcm_mix_if.sv
// Sample bus between the per-channel gain stage (master) and the stereo mixer (slave).
interface jt10_adpcm_mix_if;
   import jt10_adpcm_mix_pkg::*;

   logic [NUM_CH-1:0]  en_ch;
   logic               match;
   logic [1:0]         lr;
   logic signed [15:0] pcm_in;
   logic signed [15:0] pcm_left;
   logic signed [15:0] pcm_right;
   logic               sample;

   modport master (
      output en_ch, match, lr, pcm_in,
      input  pcm_left, pcm_right, sample
   );

   modport slave (
      input  en_ch, match, lr, pcm_in,
      output pcm_left, pcm_right, sample
   );

endinterface

// File: rtl/jt10_adpcm_sat.sv
// Combinational clamp of a signed ACC_W-bit sum to the signed 16-bit output range.
module jt10_adpcm_sat
   import jt10_adpcm_mix_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0] din_i,
   output logic signed [15:0]      dout_o
);

   localparam logic signed [ACC_W-1:0] MAX_X = {{(ACC_W-16){SAT_MAX[15]}}, SAT_MAX};
   localparam logic signed [ACC_W-1:0] MIN_X = {{(ACC_W-16){SAT_MIN[15]}}, SAT_MIN};

   // Clamp out-of-range sums, pass in-range values through unchanged
   always_comb begin
      dout_o = din_i[15:0];
      if (din_i > MAX_X) begin
         dout_o = SAT_MAX;
      end else if (din_i < MIN_X) begin
         dout_o = SAT_MIN;
      end else begin
         dout_o = din_i[15:0];
      end
   end

endmodule

// File: rtl/jt10_adpcm_mix.sv
// Six-channel stereo ADPCM mixer: accumulates panned samples per frame and publishes
// saturated left/right totals with a one-clock sample pulse when channel 5 closes the frame.
module jt10_adpcm_mix
   import jt10_adpcm_mix_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   jt10_adpcm_mix_if.slave  mix
);

   logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic signed [ACC_W-1:0] pcm_ext_s, sum_l_s, sum_r_s;
   logic signed [15:0]      sat_l_s, sat_r_s;
   logic signed [15:0]      pcm_left_q, pcm_left_d, pcm_right_q, pcm_right_d;
   logic                    synced_q, synced_d;
   logic                    sample_q, sample_d;
   logic                    valid_s, frame_end_s;

   assign valid_s     = cen & mix.match;
   assign frame_end_s = is_frame_end(mix.en_ch);
   assign pcm_ext_s   = {{(ACC_W-16){mix.pcm_in[15]}}, mix.pcm_in};
   assign sum_l_s     = acc_l_q + (mix.lr[1] ? pcm_ext_s : {ACC_W{1'b0}});
   assign sum_r_s     = acc_r_q + (mix.lr[0] ? pcm_ext_s : {ACC_W{1'b0}});

   jt10_adpcm_sat #(.ACC_W(ACC_W)) u_sat_l (.din_i(sum_l_s), .dout_o(sat_l_s));
   jt10_adpcm_sat #(.ACC_W(ACC_W)) u_sat_r (.din_i(sum_r_s), .dout_o(sat_r_s));

   // Next-state: accumulate, or on frame end publish (once synced) and clear
   always_comb begin
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      pcm_left_d  = pcm_left_q;
      pcm_right_d = pcm_right_q;
      synced_d    = synced_q;
      sample_d    = 1'b0;
      if (valid_s) begin
         if (frame_end_s) begin
            acc_l_d  = {ACC_W{1'b0}};
            acc_r_d  = {ACC_W{1'b0}};
            synced_d = 1'b1;
            if (synced_q) begin
               pcm_left_d  = sat_l_s;
               pcm_right_d = sat_r_s;
               sample_d    = 1'b1;
            end else begin
               sample_d = 1'b0;
            end
         end else if (synced_q) begin
            acc_l_d = sum_l_s;
            acc_r_d = sum_r_s;
         end else begin
            // The partial frame before the first frame end is discarded
            acc_l_d = {ACC_W{1'b0}};
            acc_r_d = {ACC_W{1'b0}};
         end
      end else begin
         sample_d = 1'b0;
      end
   end

   // State registers with synchronous reset taking priority over cen/match
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_l_q     <= {ACC_W{1'b0}};
         acc_r_q     <= {ACC_W{1'b0}};
         pcm_left_q  <= 16'sd0;
         pcm_right_q <= 16'sd0;
         synced_q    <= 1'b0;
         sample_q    <= 1'b0;
      end else begin
         acc_l_q     <= acc_l_d;
         acc_r_q     <= acc_r_d;
         pcm_left_q  <= pcm_left_d;
         pcm_right_q <= pcm_right_d;
         synced_q    <= synced_d;
         sample_q    <= sample_d;
      end
   end

   assign mix.pcm_left  = pcm_left_q;
   assign mix.pcm_right = pcm_right_q;
   assign mix.sample    = sample_q;

endmodule

// File: tb/tb_jt10_adpcm_mix.sv
// Self-checking bench for jt10_adpcm_mix: a behavioural model pushes expected frame
// results into a scoreboard that is popped on every sample pulse.
module tb_jt10_adpcm_mix;
   import jt10_adpcm_mix_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cen = 1'b0;

   jt10_adpcm_mix_if mix_bus ();

   jt10_adpcm_mix #(.ACC_W(19)) dut (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .mix (mix_bus)
   );

   always #5 clk = ~clk;

   typedef struct { int l; int r; } exp_t;
   exp_t sb_q[$];

   int  n_cmp = 0;
   int  n_bad = 0;
   int  n_pulse = 0;
   int  m_acc_l = 0, m_acc_r = 0;
   int  m_out_l = 0, m_out_r = 0;
   bit  m_synced = 1'b0;

   task automatic check_val(input string tag, input int act, input int exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      else if (v < -32768) return -32768;
      else return v;
   endfunction

   // Scoreboard pop on every sample pulse, sampled away from the rising edge
   always @(negedge clk) begin
      if (mix_bus.sample === 1'b1) begin
         n_pulse++;
         if (sb_q.size() == 0) begin
            check_val("unexpected_sample", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("sb_left",  int'($signed(mix_bus.pcm_left)),  e.l);
            check_val("sb_right", int'($signed(mix_bus.pcm_right)), e.r);
         end
      end
   end

   task automatic send(input logic [5:0] en, input logic [1:0] lr_v, input int val);
      int add_l, add_r;
      @(negedge clk);
      cen            = 1'b1;
      mix_bus.match  = 1'b1;
      mix_bus.en_ch  = en;
      mix_bus.lr     = lr_v;
      mix_bus.pcm_in = 16'(val);
      add_l = lr_v[1] ? val : 0;
      add_r = lr_v[0] ? val : 0;
      if (en[5]) begin
         if (m_synced) begin
            exp_t e;
            m_out_l = sat16(m_acc_l + add_l);
            m_out_r = sat16(m_acc_r + add_r);
            e.l = m_out_l;
            e.r = m_out_r;
            sb_q.push_back(e);
         end
         m_synced = 1'b1;
         m_acc_l  = 0;
         m_acc_r  = 0;
      end else if (m_synced) begin
         m_acc_l += add_l;
         m_acc_r += add_r;
      end
      @(posedge clk);
      #1;
      cen           = 1'b0;
      mix_bus.match = 1'b0;
   endtask

   task automatic frame(input logic [1:0] lr_v, input int val);
      for (int ch = 0; ch < 6; ch++) send(6'b1 << ch, lr_v, val);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      cen            = 1'b1;
      mix_bus.match  = 1'b1;
      mix_bus.en_ch  = 6'b100000;
      mix_bus.lr     = 2'b11;
      mix_bus.pcm_in = 16'sd1234;
      @(posedge clk);
      #1;
      rst = 1'b0; cen = 1'b0; mix_bus.match = 1'b0;
      m_synced = 1'b0; m_acc_l = 0; m_acc_r = 0; m_out_l = 0; m_out_r = 0;
   endtask

   task automatic check_out(input string tag, input int l, input int r);
      check_val({tag, "_l"}, int'($signed(mix_bus.pcm_left)),  l);
      check_val({tag, "_r"}, int'($signed(mix_bus.pcm_right)), r);
   endtask

   initial begin
      mix_bus.en_ch  = 6'd0;
      mix_bus.match  = 1'b0;
      mix_bus.lr     = 2'b00;
      mix_bus.pcm_in = 16'sd0;
      do_reset();
      check_out("reset", 0, 0);
      check_val("reset_sample", int'(mix_bus.sample), 0);

      // Sync frame is discarded, the second one publishes
      frame(2'b11, 100);
      check_out("sync_frame", 0, 0);
      check_val("sync_pulses", n_pulse, 0);
      frame(2'b11, 100);
      check_out("frame2", 600, 600);

      frame(2'b10, 30000);
      check_out("sat_pos", 32767, 0);
      frame(2'b01, -30000);
      check_out("sat_neg", 0, -32768);

      send(6'b000001, 2'b10, 1000);
      send(6'b000010, 2'b01, -250);
      send(6'b000100, 2'b00, 500);
      for (int ch = 3; ch < 6; ch++) send(6'b1 << ch, 2'b11, 0);
      check_out("pan", 1000, -250);
      frame(2'b11, 0);
      check_out("zero", 0, 0);

      // Zero and multi-hot tags without bit 5 accumulate; multi-hot with bit 5 closes
      send(6'b000000, 2'b11, 7);
      send(6'b000011, 2'b10, 11);
      send(6'b100001, 2'b01, 13);
      check_out("multihot", 18, 20);

      // match held high with cen low must not disturb anything
      send(6'b000001, 2'b11, 3);
      @(negedge clk);
      mix_bus.match  = 1'b1;
      mix_bus.pcm_in = 16'sd5000;
      mix_bus.lr     = 2'b11;
      for (int i = 0; i < 20; i++) begin
         mix_bus.en_ch = 6'b1 << (i % 6);
         @(negedge clk);
      end
      mix_bus.match = 1'b0;
      check_out("cen_low", 18, 20);
      for (int ch = 1; ch < 6; ch++) send(6'b1 << ch, 2'b11, 1);
      check_out("cen_low_after", 8, 8);

      // Mid-frame reset discards the partial sums and forces a new sync frame
      for (int ch = 0; ch < 3; ch++) send(6'b1 << ch, 2'b11, 7000);
      do_reset();
      check_out("mid_reset", 0, 0);
      frame(2'b11, 10);
      check_out("post_reset_sync", 0, 0);
      frame(2'b11, 10);
      check_out("post_reset", 60, 60);

      repeat (3) @(negedge clk);
      check_val("sb_pending", sb_q.size(), 0);
      check_val("pulse_count", n_pulse, 8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
